memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Y86-64 memory stage: IDLE/ACCESS/DONE handshake FSM wrapped around a 64-bit data memory.
// Optional macro MEM_BOUNDS_CHECK_EN turns out-of-range or misaligned addresses into stat = ADR.
module memory_stage #(
    parameter int MEM_WORDS = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic        [3:0]  icode,
    input  logic signed [63:0] valE,
    input  logic signed [63:0] valA,
    input  logic        [63:0] valP,
    output logic               out_valid,
    input  logic               out_ready,
    output logic        [63:0] valM,
    output logic        [63:0] valE_out,
    output logic        [3:0]  icode_out,
    output logic        [2:0]  stat
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    state_t        state_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [63:0]   valm_r;
    logic [63:0]   vale_out_r;
    logic [3:0]    icode_out_r;
    logic [2:0]    stat_r;
    logic [3:0]    icode_lat_r;
    logic [63:0]   vale_lat_r;
    logic [63:0]   vala_lat_r;
    logic [63:0]   valp_lat_r;
    logic [63:0]   mem_r [MEM_WORDS];

    logic          is_write_s;
    logic          is_read_s;
    logic          adr_err_s;
    logic          do_write_s;
    logic          do_read_s;
    logic [63:0]   addr_s;
    logic [63:0]   wdata_s;
    logic [AW-1:0] idx_s;
    logic [2:0]    stat_s;

    // Decode the latched instruction into access type, address and write data.
    always_comb begin
        is_write_s = 1'b0;
        is_read_s  = 1'b0;
        addr_s     = vale_lat_r;
        wdata_s    = vala_lat_r;
        case (icode_lat_r)
            4'h4, 4'hA: is_write_s = 1'b1;
            4'h8: begin
                is_write_s = 1'b1;
                wdata_s    = valp_lat_r;
            end
            4'h5: is_read_s = 1'b1;
            4'h9, 4'hB: begin
                is_read_s = 1'b1;
                addr_s    = vala_lat_r;
            end
            default: begin
                is_write_s = 1'b0;
                is_read_s  = 1'b0;
            end
        endcase
    end

`ifdef MEM_BOUNDS_CHECK_EN
    // Flag memory accesses outside the array or not on an 8-byte boundary.
    always_comb begin
        adr_err_s = (is_write_s | is_read_s) & ((|addr_s[63:AW+3]) | (|addr_s[2:0]));
    end
`else
    logic unused_addr_s;
    // Without checking, high address bits wrap and the byte offset is ignored.
    always_comb begin
        adr_err_s     = 1'b0;
        unused_addr_s = ^{addr_s[63:AW+3], addr_s[2:0]};
    end
`endif

    // Status priority and access qualification; INS icodes never decode to an access.
    always_comb begin
        idx_s      = addr_s[AW+2:3];
        do_write_s = is_write_s & ~adr_err_s;
        do_read_s  = is_read_s & ~adr_err_s;
        if (icode_lat_r > 4'hB) begin
            stat_s = STAT_INS;
        end else if (icode_lat_r == 4'h0) begin
            stat_s = STAT_HLT;
        end else if (adr_err_s) begin
            stat_s = STAT_ADR;
        end else begin
            stat_s = STAT_AOK;
        end
    end

    // Handshake FSM with registered handshake flags and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            valm_r      <= 64'd0;
            vale_out_r  <= 64'd0;
            icode_out_r <= 4'd0;
            stat_r      <= STAT_AOK;
            icode_lat_r <= 4'd0;
            vale_lat_r  <= 64'd0;
            vala_lat_r  <= 64'd0;
            valp_lat_r  <= 64'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        icode_lat_r <= icode;
                        vale_lat_r  <= valE;
                        vala_lat_r  <= valA;
                        valp_lat_r  <= valP;
                        in_ready_r  <= 1'b0;
                        state_r     <= ACCESS;
                    end
                end
                ACCESS: begin
                    valm_r      <= do_read_s ? mem_r[idx_s] : 64'd0;
                    vale_out_r  <= vale_lat_r;
                    icode_out_r <= icode_lat_r;
                    stat_r      <= stat_s;
                    out_valid_r <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Data memory is not reset; a reset before the ACCESS edge leaves state_r out of ACCESS.
    always_ff @(posedge clk) begin
        if (state_r == ACCESS && do_write_s) begin
            mem_r[idx_s] <= wdata_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign valM      = valm_r;
    assign valE_out  = vale_out_r;
    assign icode_out = icode_out_r;
    assign stat      = stat_r;
endmodule
